// File: rtl/gpio_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_v2_pkg
// Description : Shared constants for the gpio_ctrl_v2 controller: register
//               byte addresses, CTRL bit positions and the debounce threshold.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_v2_pkg;

  // Register byte addresses (full 32-bit compare)
  localparam logic [31:0] ADR_IN      = 32'h0000_0000;
  localparam logic [31:0] ADR_OUT     = 32'h0000_0004;
  localparam logic [31:0] ADR_OE      = 32'h0000_0008;
  localparam logic [31:0] ADR_INTE    = 32'h0000_000C;
  localparam logic [31:0] ADR_PTRIG   = 32'h0000_0010;
  localparam logic [31:0] ADR_AUX     = 32'h0000_0014;
  localparam logic [31:0] ADR_CTRL    = 32'h0000_0018;
  localparam logic [31:0] ADR_INTS    = 32'h0000_001C;
  localparam logic [31:0] ADR_BOTH    = 32'h0000_0020;
  localparam logic [31:0] ADR_OUT_SET = 32'h0000_0024;
  localparam logic [31:0] ADR_OUT_CLR = 32'h0000_0028;
  localparam logic [31:0] ADR_OUT_TGL = 32'h0000_002C;
  localparam logic [31:0] ADR_DEB_EN  = 32'h0000_0030;
  localparam logic [31:0] ADR_DEB_PRD = 32'h0000_0034;

  // CTRL register bit positions
  localparam int CTRL_INTE_GLOBAL = 0;
  localparam int CTRL_INTS_ANY    = 1;

  // Number of consecutive disagreeing ticks before the filter follows syn
  localparam logic [1:0] DEB_THRESH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gpio_ctrl_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl_v2_if
// Description : Register bus between the fabric (master) and gpio_ctrl_v2
//               (slave).
//   gpio_we     : single-cycle write strobe
//   gpio_adr    : byte address
//   gpio_dat_i  : write data
//   gpio_dat_o  : registered read data
//   gpio_inta_o : interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_ctrl_v2_if;
  logic        gpio_we;
  logic [31:0] gpio_adr;
  logic [31:0] gpio_dat_i;
  logic [31:0] gpio_dat_o;
  logic        gpio_inta_o;

  modport master (
    output gpio_we, gpio_adr, gpio_dat_i,
    input  gpio_dat_o, gpio_inta_o
  );

  modport slave (
    input  gpio_we, gpio_adr, gpio_dat_i,
    output gpio_dat_o, gpio_inta_o
  );
endinterface
`default_nettype wire

// File: rtl/gpio_v2_infilt.sv
`default_nettype none
// ============================================================================
// Module      : gpio_v2_infilt
// Description : Per-bit input synchroniser followed by a tick-driven
//               debounce filter.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   in_pad_i         : asynchronous pad inputs
//   tick             : prescaler tick that advances the debounce counters
//   deb_en           : per-bit filter enable (0 = filt follows syn directly)
//   filt             : filtered input (registered)
//   filt_nxt         : value filt takes at the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_v2_infilt #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             sys_clk,
  input  wire logic             sys_rst,
  input  wire logic [WIDTH-1:0] in_pad_i,
  input  wire logic             tick,
  input  wire logic [WIDTH-1:0] deb_en,
  output logic      [WIDTH-1:0] filt,
  output logic      [WIDTH-1:0] filt_nxt
);
  import gpio_v2_pkg::*;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  syn;
  logic [WIDTH-1:0]                  filt_q, filt_d;
  logic [WIDTH-1:0][1:0]             cnt_q, cnt_d;

  assign syn      = sync_q[SYNC_STAGES-1];
  assign filt     = filt_q;
  assign filt_nxt = filt_d;

  always_comb begin
    // Stage 0 samples the pad, higher stages shift along.
    sync_d = {sync_q[SYNC_STAGES-2:0], in_pad_i};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!deb_en[i]) begin
        filt_d[i] = syn[i];
        cnt_d[i]  = 2'd0;
      end else if (tick) begin
        if (syn[i] != filt_q[i]) begin
          // Third disagreeing tick in a row: accept the new level.
          if (cnt_q[i] == DEB_THRESH - 2'd1) begin
            filt_d[i] = syn[i];
            cnt_d[i]  = 2'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 2'd1;
          end
        end else begin
          cnt_d[i] = 2'd0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl_v2
// Description : Parametrised GPIO controller with register-mapped bus slave,
//               input synchroniser/debounce, edge interrupts (W1C status)
//               and atomic set/clear/toggle output aliases.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   bus              : register bus (slave side)
//   aux_i            : alternate-function output data
//   in_pad_i         : asynchronous pad inputs
//   out_pad_o        : pad output data
//   oen_padoe_o      : pad output enable (1 = drive)
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl_v2 #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 8
) (
  input  wire logic             sys_clk,
  input  wire logic             sys_rst,
  gpio_ctrl_v2_if.slave         bus,
  input  wire logic [WIDTH-1:0] aux_i,
  input  wire logic [WIDTH-1:0] in_pad_i,
  output logic      [WIDTH-1:0] out_pad_o,
  output logic      [WIDTH-1:0] oen_padoe_o
);
  import gpio_v2_pkg::*;

  logic [WIDTH-1:0]     out_q, out_d, oe_q, oe_d, inte_q, inte_d;
  logic [WIDTH-1:0]     ptrig_q, ptrig_d, aux_q, aux_d, both_q, both_d;
  logic [WIDTH-1:0]     deb_en_q, deb_en_d, ints_q, ints_d;
  logic                 gie_q, gie_d, inta_q, inta_d;
  logic [DEB_CNT_W-1:0] prd_q, prd_d, pcnt_q, pcnt_d;
  logic [31:0]          dat_o_q, dat_o_d;

  logic [WIDTH-1:0]     wdat, w1c, filt, filt_nxt, rise, fall, ev;
  logic                 tick, wr_prd;

  gpio_v2_infilt #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_infilt (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_pad_i (in_pad_i),
    .tick     (tick),
    .deb_en   (deb_en_q),
    .filt     (filt),
    .filt_nxt (filt_nxt)
  );

  assign wdat        = bus.gpio_dat_i[WIDTH-1:0];
  assign out_pad_o   = (out_q & ~aux_q) | (aux_i & aux_q);
  assign oen_padoe_o = oe_q;
  assign bus.gpio_dat_o  = dat_o_q;
  assign bus.gpio_inta_o = inta_q;

  // Edges are judged on the filter's next value so INTS sets on the same
  // edge that filt changes.
  assign rise = ~filt & filt_nxt;
  assign fall = filt & ~filt_nxt;
  assign ev   = inte_q & ((both_q & (rise | fall)) |
                          (~both_q & ((ptrig_q & rise) | (~ptrig_q & fall))));

  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    inte_d   = inte_q;
    ptrig_d  = ptrig_q;
    aux_d    = aux_q;
    both_d   = both_q;
    deb_en_d = deb_en_q;
    gie_d    = gie_q;
    prd_d    = prd_q;
    w1c      = '0;
    wr_prd   = 1'b0;
    if (bus.gpio_we) begin
      case (bus.gpio_adr)
        ADR_OUT:     out_d    = wdat;
        ADR_OE:      oe_d     = wdat;
        ADR_INTE:    inte_d   = wdat;
        ADR_PTRIG:   ptrig_d  = wdat;
        ADR_AUX:     aux_d    = wdat;
        ADR_CTRL:    gie_d    = bus.gpio_dat_i[CTRL_INTE_GLOBAL];
        ADR_INTS:    w1c      = wdat;
        ADR_BOTH:    both_d   = wdat;
        ADR_OUT_SET: out_d    = out_q | wdat;
        ADR_OUT_CLR: out_d    = out_q & ~wdat;
        ADR_OUT_TGL: out_d    = out_q ^ wdat;
        ADR_DEB_EN:  deb_en_d = wdat;
        ADR_DEB_PRD: begin
          prd_d  = bus.gpio_dat_i[DEB_CNT_W-1:0];
          wr_prd = 1'b1;
        end
        default: ;
      endcase
    end

    // New events win over a simultaneous clear.
    ints_d = (ints_q & ~w1c) | (ev & {WIDTH{gie_q}});
    inta_d = gie_q & (|ints_q);

    tick   = (pcnt_q == prd_q);
    pcnt_d = (wr_prd || tick) ? '0 : pcnt_q + 1'b1;

    dat_o_d = '0;
    case (bus.gpio_adr)
      ADR_IN:      dat_o_d[WIDTH-1:0] = filt;
      ADR_OUT:     dat_o_d[WIDTH-1:0] = out_q;
      ADR_OE:      dat_o_d[WIDTH-1:0] = oe_q;
      ADR_INTE:    dat_o_d[WIDTH-1:0] = inte_q;
      ADR_PTRIG:   dat_o_d[WIDTH-1:0] = ptrig_q;
      ADR_AUX:     dat_o_d[WIDTH-1:0] = aux_q;
      ADR_CTRL: begin
        dat_o_d[CTRL_INTE_GLOBAL] = gie_q;
        dat_o_d[CTRL_INTS_ANY]    = |ints_q;
      end
      ADR_INTS:    dat_o_d[WIDTH-1:0] = ints_q;
      ADR_BOTH:    dat_o_d[WIDTH-1:0] = both_q;
      ADR_DEB_EN:  dat_o_d[WIDTH-1:0] = deb_en_q;
      ADR_DEB_PRD: dat_o_d[DEB_CNT_W-1:0] = prd_q;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_q    <= '0;
      oe_q     <= '0;
      inte_q   <= '0;
      ptrig_q  <= '0;
      aux_q    <= '0;
      both_q   <= '0;
      deb_en_q <= '0;
      ints_q   <= '0;
      gie_q    <= 1'b0;
      inta_q   <= 1'b0;
      prd_q    <= '0;
      pcnt_q   <= '0;
      dat_o_q  <= '0;
    end else begin
      out_q    <= out_d;
      oe_q     <= oe_d;
      inte_q   <= inte_d;
      ptrig_q  <= ptrig_d;
      aux_q    <= aux_d;
      both_q   <= both_d;
      deb_en_q <= deb_en_d;
      ints_q   <= ints_d;
      gie_q    <= gie_d;
      inta_q   <= inta_d;
      prd_q    <= prd_d;
      pcnt_q   <= pcnt_d;
      dat_o_q  <= dat_o_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_ctrl_v2
// Description : Self-checking bench for gpio_ctrl_v2 (WIDTH=32, two sync
//               stages). Directed scenarios plus random traffic, compared
//               against a behavioural model of the register/pad behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl_v2;
  import gpio_v2_pkg::*;

  localparam int WIDTH = 32;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [WIDTH-1:0] aux_i, in_pad_i, out_pad_o, oen_padoe_o;

  gpio_ctrl_v2_if bus ();

  gpio_ctrl_v2 #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .DEB_CNT_W   (8)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bus         (bus.slave),
    .aux_i       (aux_i),
    .in_pad_i    (in_pad_i),
    .out_pad_o   (out_pad_o),
    .oen_padoe_o (oen_padoe_o)
  );

  always #5 sys_clk = ~sys_clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit [31:0] m_out, m_oe, m_inte, m_ptrig, m_aux, m_both, m_deb_en, m_ints;
  bit [31:0] m_filt, m_dat_o;
  bit        m_gie, m_inta;
  int        m_prd, m_pcnt;
  bit [31:0] m_hist [2];  // pad value one and two edges ago
  int        m_cnt  [32];

  function automatic bit [31:0] model_read(input bit [31:0] a);
    case (a)
      ADR_IN:      return m_filt;
      ADR_OUT:     return m_out;
      ADR_OE:      return m_oe;
      ADR_INTE:    return m_inte;
      ADR_PTRIG:   return m_ptrig;
      ADR_AUX:     return m_aux;
      ADR_CTRL:    return {30'd0, (m_ints != 0), m_gie};
      ADR_INTS:    return m_ints;
      ADR_BOTH:    return m_both;
      ADR_DEB_EN:  return m_deb_en;
      ADR_DEB_PRD: return 32'(m_prd);
      default:     return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit [31:0] syn, nf, ev, rd, d, a;
    bit        tick, we;
    we = bus.gpio_we;
    a  = bus.gpio_adr;
    d  = bus.gpio_dat_i;
    if (sys_rst) begin
      {m_out, m_oe, m_inte, m_ptrig, m_aux, m_both, m_deb_en, m_ints} = '0;
      m_filt = '0; m_dat_o = '0; m_gie = 0; m_inta = 0;
      m_prd = 0; m_pcnt = 0; m_hist[0] = '0; m_hist[1] = '0;
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      return;
    end
    tick = (m_pcnt == m_prd);
    syn  = m_hist[1];
    nf   = m_filt;
    for (int i = 0; i < 32; i++) begin
      if (!m_deb_en[i]) begin
        nf[i] = syn[i]; m_cnt[i] = 0;
      end else if (tick) begin
        if (syn[i] != m_filt[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == 3) begin nf[i] = syn[i]; m_cnt[i] = 0; end
        end else m_cnt[i] = 0;
      end
    end
    // An edge's direction is simply the new level.
    for (int i = 0; i < 32; i++)
      ev[i] = (nf[i] != m_filt[i]) && m_inte[i] && (m_both[i] || (m_ptrig[i] == nf[i]));
    rd     = model_read(a);
    m_inta = m_gie && (m_ints != 0);
    m_ints = (m_ints & ~((we && a == ADR_INTS) ? d : 32'd0)) | (m_gie ? ev : 32'd0);
    m_pcnt = ((we && a == ADR_DEB_PRD) || tick) ? 0 : m_pcnt + 1;
    m_filt = nf;
    m_hist[1] = m_hist[0];
    m_hist[0] = in_pad_i;
    m_dat_o = rd;
    if (we) begin
      case (a)
        ADR_OUT:     m_out    = d;
        ADR_OE:      m_oe     = d;
        ADR_INTE:    m_inte   = d;
        ADR_PTRIG:   m_ptrig  = d;
        ADR_AUX:     m_aux    = d;
        ADR_CTRL:    m_gie    = d[0];
        ADR_BOTH:    m_both   = d;
        ADR_OUT_SET: m_out    = m_out | d;
        ADR_OUT_CLR: m_out    = m_out & ~d;
        ADR_OUT_TGL: m_out    = m_out ^ d;
        ADR_DEB_EN:  m_deb_en = d;
        ADR_DEB_PRD: m_prd    = int'(d[7:0]);
        default: ;
      endcase
    end
  endtask

  always @(posedge sys_clk) model_step();

  // Continuous comparison of every output against the model.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      #1;
      chk("dat_o", bus.gpio_dat_o, m_dat_o);
      chk("inta", {31'd0, bus.gpio_inta_o}, {31'd0, m_inta});
      chk("out_pad", out_pad_o, (m_out & ~m_aux) | (aux_i & m_aux));
      chk("oen", oen_padoe_o, m_oe);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] addrs [16] = '{ADR_IN, ADR_OUT, ADR_OE, ADR_INTE, ADR_PTRIG, ADR_AUX,
                              ADR_CTRL, ADR_INTS, ADR_BOTH, ADR_OUT_SET, ADR_OUT_CLR,
                              ADR_OUT_TGL, ADR_DEB_EN, ADR_DEB_PRD, 32'h38, 32'h8000_0004};

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    bus.gpio_we = 1'b1; bus.gpio_adr = a; bus.gpio_dat_i = d;
    @(negedge sys_clk);
    bus.gpio_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge sys_clk);
    bus.gpio_we = 1'b0; bus.gpio_adr = a;
    @(negedge sys_clk);
    #1 chk(tag, bus.gpio_dat_o, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    bus.gpio_we = 1'b0; bus.gpio_adr = '0; bus.gpio_dat_i = '0;
    aux_i = '0; in_pad_i = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    // 1: reset state
    for (int i = 0; i < 16; i++) rd_chk("rst_read", addrs[i], 32'd0);
    #1 chk("rst_out_pad", out_pad_o, 32'd0);
    chk("rst_oen", oen_padoe_o, 32'd0);
    chk("rst_inta", {31'd0, bus.gpio_inta_o}, 32'd0);

    // 2: output aliases and AUX muxing
    wr(ADR_OUT, 32'hF0);
    wr(ADR_OUT_SET, 32'h0F);
    wr(ADR_OUT_CLR, 32'h30);
    wr(ADR_OUT_TGL, 32'h101);
    rd_chk("out_alias", ADR_OUT, 32'h1CE);
    chk("out_pad_plain", out_pad_o, 32'h1CE);
    rd_chk("out_set_rd0", ADR_OUT_SET, 32'd0);
    wr(ADR_AUX, 32'h1);
    @(negedge sys_clk) aux_i = 32'h1;
    @(negedge sys_clk) #1 chk("out_pad_aux", out_pad_o, 32'h1CF);

    // 3: rising-edge interrupt and its latency
    wr(ADR_INTE, 32'h3);
    wr(ADR_PTRIG, 32'h1);
    wr(ADR_BOTH, 32'h0);
    wr(ADR_CTRL, 32'h1);
    @(negedge sys_clk) in_pad_i[0] = 1'b1;
    repeat (3) @(negedge sys_clk);
    #1 chk("inta_early", {31'd0, bus.gpio_inta_o}, 32'd0);
    @(negedge sys_clk) #1 chk("inta_k3", {31'd0, bus.gpio_inta_o}, 32'd1);
    rd_chk("ints_rise0", ADR_INTS, 32'h1);
    @(negedge sys_clk) in_pad_i[1] = 1'b1;
    idle(4);
    rd_chk("ints_no_rise1", ADR_INTS, 32'h1);
    @(negedge sys_clk) in_pad_i[1] = 1'b0;
    idle(4);
    rd_chk("ints_fall1", ADR_INTS, 32'h3);
    rd_chk("ctrl_any", ADR_CTRL, 32'h3);

    // 4: set wins over simultaneous W1C, then a plain clear
    @(negedge sys_clk) in_pad_i[0] = 1'b0;
    idle(4);
    wr(ADR_INTS, 32'h1);
    rd_chk("ints_clr0", ADR_INTS, 32'h2);
    @(negedge sys_clk) in_pad_i[0] = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    bus.gpio_we = 1'b1; bus.gpio_adr = ADR_INTS; bus.gpio_dat_i = 32'h1;
    @(negedge sys_clk) bus.gpio_we = 1'b0;
    rd_chk("ints_set_wins", ADR_INTS, 32'h3);
    wr(ADR_INTS, 32'h3);
    @(negedge sys_clk) #1 chk("inta_cleared", {31'd0, bus.gpio_inta_o}, 32'd0);
    rd_chk("ints_zero", ADR_INTS, 32'h0);

    // 5: debounce rejects a short glitch, accepts a held level
    @(negedge sys_clk) in_pad_i[0] = 1'b0;
    idle(4);
    wr(ADR_DEB_PRD, 32'd3);
    wr(ADR_DEB_EN, 32'h1);
    @(negedge sys_clk) in_pad_i[0] = 1'b1;
    idle(6);
    in_pad_i[0] = 1'b0;
    idle(20);
    rd_chk("deb_glitch", ADR_IN, 32'h0);
    @(negedge sys_clk) in_pad_i[0] = 1'b1;
    idle(20);
    rd_chk("deb_held", ADR_IN, 32'h1);

    // 6: both-edge mode, then reset in the middle of a debounce
    wr(ADR_BOTH, 32'h4);
    wr(ADR_INTE, 32'h4);
    wr(ADR_CTRL, 32'h1);
    wr(ADR_INTS, 32'hFFFF_FFFF);
    @(negedge sys_clk) in_pad_i[2] = 1'b1;
    idle(5);
    rd_chk("both_rise", ADR_INTS, 32'h4);
    wr(ADR_INTS, 32'h4);
    @(negedge sys_clk) in_pad_i[2] = 1'b0;
    idle(5);
    rd_chk("both_fall", ADR_INTS, 32'h4);
    @(negedge sys_clk) in_pad_i[0] = 1'b0;
    idle(5);
    sys_rst = 1'b1;
    @(negedge sys_clk) sys_rst = 1'b0;
    #1 chk("rst_mid_inta", {31'd0, bus.gpio_inta_o}, 32'd0);
    chk("rst_mid_out_pad", out_pad_o, 32'd0);
    for (int i = 0; i < 14; i++) rd_chk("rst_mid_read", addrs[i], 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] a;
      @(negedge sys_clk);
      sys_rst  = ($urandom_range(0, 799) == 0);
      aux_i    = $urandom;
      in_pad_i = in_pad_i ^ ($urandom & $urandom & $urandom & $urandom);
      a = addrs[$urandom_range(0, 15)];
      bus.gpio_adr = a;
      if ($urandom_range(0, 3) == 0) begin
        bus.gpio_we    = 1'b1;
        bus.gpio_dat_i = (a == ADR_DEB_PRD) ? 32'($urandom_range(0, 3)) : $urandom;
      end else begin
        bus.gpio_we = 1'b0;
      end
    end
    @(negedge sys_clk);
    bus.gpio_we = 1'b0;
    sys_rst = 1'b0;
    idle(2);
    #2;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
